sr_flag_arbiter: RTL and testbench

//  Round-robin arbiter sharing one bank of SR-style flag bits between NREQ requesters.

---
 rtl/sr_ctrl_pkg.sv | 25 ++
 rtl/sr_flag_arbiter_if.sv | 15 +
 rtl/rr_arbiter.sv | 48 ++++
 rtl/sr_flag_arbiter.sv | 85 ++++++++
 tb/tb_sr_flag_arbiter.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/sr_ctrl_pkg.sv
// Shared types and helpers for the SR flag arbiter: command op encoding,
// default sizing and a constant-safe clog2.
package sr_ctrl_pkg;

  // Command op is the concatenation {S,R} of a granted request.
  typedef enum logic [1:0] {
    OP_HOLD = 2'b00,
    OP_CLR  = 2'b01,
    OP_SET  = 2'b10,
    OP_ILL  = 2'b11
  } op_e;

  localparam int DEF_NREQ  = 4;
  localparam int DEF_NFLAG = 8;
  localparam int DEF_IDXW  = 3;

  // Minimum of 1 so single-value index fields still get a legal width.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/sr_flag_arbiter_if.sv
// Request-side bundle of the SR flag arbiter: per-requester valid/S/R/index
// commands in, one-hot ready back.
interface sr_flag_arbiter_if #(
  parameter int NREQ = 4,
  parameter int IDXW = 3
);
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_s;
  logic [NREQ-1:0]      req_r;
  logic [NREQ*IDXW-1:0] req_idx;
  logic [NREQ-1:0]      req_ready;

  modport master (output req_valid, req_s, req_r, req_idx, input req_ready);
  modport slave  (input req_valid, req_s, req_r, req_idx, output req_ready);
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: picks the first requester at or after ptr, wrapping,
// and moves ptr past the winner whenever the grant is consumed.
module rr_arbiter
  import sr_ctrl_pkg::*;
#(
  parameter  int N = 4,
  localparam int W = clog2(N)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] gnt,
  output logic [W-1:0] gnt_idx
);

  logic [W-1:0] ptr;
  logic         found;
  int           cand;

  // NOTE: every signal driven here gets a default before the search loop so
  // no path leaves a variable unassigned, which would infer a latch.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = 0;
    for (int k = 0; k < N; k++) begin
      cand = (int'(ptr) + k) % N;
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        gnt_idx   = W'(cand);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (gnt_idx == W'(N - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

endmodule

// File: rtl/sr_flag_arbiter.sv
// Shares one SR-style flag bank between NREQ requesters; one granted command
// per clock, S=R=1 and out-of-range indices trapped as sticky errors.
module sr_flag_arbiter
  import sr_ctrl_pkg::*;
#(
  parameter  int NREQ  = DEF_NREQ,
  parameter  int NFLAG = DEF_NFLAG,
  parameter  int IDXW  = DEF_IDXW,
  localparam int SW    = clog2(NREQ)
) (
  input  logic              clk,
  input  logic              reset,
  sr_flag_arbiter_if.slave  bus,
  input  logic              err_clr,
  output logic [NFLAG-1:0]  flags,
  output logic              err_ill,
  output logic              err_rng,
  output logic [SW-1:0]     err_src
);

  logic [NREQ-1:0]  gnt;
  logic [SW-1:0]    gnt_idx;
  logic             xfer;
  logic             cmd_s, cmd_r;
  logic [IDXW-1:0]  cmd_idx;
  op_e              op;
  logic             rng_hit, ill_hit;
  logic [NFLAG-1:0] flags_nxt;

  rr_arbiter #(.N(NREQ)) u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (bus.req_valid),
    .advance (xfer),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // Grants are suppressed while reset is held so nothing transfers.
  assign bus.req_ready = reset ? gnt : '0;
  assign xfer          = |(bus.req_valid & bus.req_ready);

  always_comb begin
    cmd_s     = bus.req_s[gnt_idx];
    cmd_r     = bus.req_r[gnt_idx];
    cmd_idx   = bus.req_idx[int'(gnt_idx)*IDXW +: IDXW];
    op        = op_e'({cmd_s, cmd_r});
    rng_hit   = xfer && (int'(cmd_idx) >= NFLAG);
    ill_hit   = xfer && !rng_hit && (op == OP_ILL);
    flags_nxt = flags;
    if (xfer && !rng_hit) begin
      for (int i = 0; i < NFLAG; i++) begin
        if (int'(cmd_idx) == i) begin
          case (op)
            OP_SET:  flags_nxt[i] = 1'b1;
            OP_CLR:  flags_nxt[i] = 1'b0;
            default: flags_nxt[i] = flags[i];
          endcase
        end
      end
    end
  end

  // A new error in the clear cycle overrides the clear: later assignments win.
  always_ff @(posedge clk) begin
    if (!reset) begin
      flags   <= '0;
      err_ill <= 1'b0;
      err_rng <= 1'b0;
      err_src <= '0;
    end else begin
      flags <= flags_nxt;
      if (err_clr) begin
        err_ill <= 1'b0;
        err_rng <= 1'b0;
        err_src <= '0;
      end
      if (rng_hit) err_rng <= 1'b1;
      if (ill_hit) err_ill <= 1'b1;
      if ((rng_hit || ill_hit) && (err_clr || !(err_ill || err_rng)))
        err_src <= gnt_idx;
    end
  end

endmodule

// File: tb/tb_sr_flag_arbiter.sv
// Bench for sr_flag_arbiter (NREQ=4, NFLAG=6): directed scenarios, then
// randomized traffic checked against a behavioural model of the flag bank.
module tb_sr_flag_arbiter;

  localparam int NREQ  = 4;
  localparam int NFLAG = 6;
  localparam int IDXW  = 3;

  logic             clk;
  logic             reset;
  logic             err_clr;
  logic [NFLAG-1:0] flags;
  logic             err_ill;
  logic             err_rng;
  logic [1:0]       err_src;

  sr_flag_arbiter_if #(.NREQ(NREQ), .IDXW(IDXW)) bus ();

  sr_flag_arbiter #(.NREQ(NREQ), .NFLAG(NFLAG), .IDXW(IDXW)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus.slave),
    .err_clr (err_clr),
    .flags   (flags),
    .err_ill (err_ill),
    .err_rng (err_rng),
    .err_src (err_src)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int tests  = 0;
  int failed = 0;

  // Reference state
  logic [NFLAG-1:0] m_flags = '0;
  bit               m_ill   = 1'b0;
  bit               m_rng   = 1'b0;
  int               m_src   = 0;
  int               m_ptr   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_winner(input logic [NREQ-1:0] v, input int p);
    for (int k = 0; k < NREQ; k++)
      if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  task automatic set_cmd(input int i, input bit v, input bit s, input bit r, input int idx);
    bus.req_valid[i]             = v;
    bus.req_s[i]                 = s;
    bus.req_r[i]                 = r;
    bus.req_idx[i*IDXW +: IDXW]  = idx[IDXW-1:0];
  endtask

  task automatic idle();
    for (int i = 0; i < NREQ; i++) set_cmd(i, 1'b0, 1'b0, 1'b0, 0);
    err_clr = 1'b0;
  endtask

  // One clock: check grant before the edge, advance the model, check state after.
  task automatic cycle();
    logic [NREQ-1:0] exp_rdy;
    int  w, idx;
    bit  s, r, prev_err;
    w = model_winner(bus.req_valid, m_ptr);
    exp_rdy = (reset && w >= 0) ? NREQ'(1 << w) : '0;
    #4;
    check("ready", 32'(bus.req_ready), 32'(exp_rdy));
    @(posedge clk);
    #1;
    if (!reset) begin
      m_flags = '0; m_ill = 0; m_rng = 0; m_src = 0; m_ptr = 0;
    end else begin
      prev_err = m_ill || m_rng;
      if (err_clr) begin m_ill = 0; m_rng = 0; m_src = 0; end
      if (w >= 0) begin
        m_ptr = (w + 1) % NREQ;
        s   = bus.req_s[w];
        r   = bus.req_r[w];
        idx = int'(bus.req_idx[w*IDXW +: IDXW]);
        if (idx >= NFLAG) begin
          m_rng = 1;
          if (err_clr || !prev_err) m_src = w;
        end else if (s && r) begin
          m_ill = 1;
          if (err_clr || !prev_err) m_src = w;
        end else if (s) begin
          m_flags[idx] = 1'b1;
        end else if (r) begin
          m_flags[idx] = 1'b0;
        end
      end
    end
    check("flags",   32'(flags),   32'(m_flags));
    check("err_ill", 32'(err_ill), 32'(m_ill));
    check("err_rng", 32'(err_rng), 32'(m_rng));
    check("err_src", 32'(err_src), 32'(m_src));
  endtask

  initial begin
    // Reset with commands pending: nothing may be granted or applied
    reset = 1'b0;
    idle();
    for (int i = 0; i < NREQ; i++) set_cmd(i, 1'b1, 1'b1, 1'b0, i);
    cycle();
    cycle();
    reset = 1'b1;
    idle();
    cycle();
    check("rst_flags", 32'(flags), 32'h0);
    check("rst_errs",  32'({err_ill, err_rng, err_src}), 32'h0);

    // Set then clear flag 5 through requester 0
    set_cmd(0, 1'b1, 1'b1, 1'b0, 5);
    cycle();
    check("set_idx5", 32'(flags), 32'h20);
    set_cmd(0, 1'b1, 1'b0, 1'b1, 5);
    cycle();
    check("clr_idx5", 32'(flags), 32'h00);

    // Fairness from ptr=0 with all requesters holding valid no-ops
    idle();
    reset = 1'b0;
    cycle();
    reset = 1'b1;
    for (int i = 0; i < NREQ; i++) set_cmd(i, 1'b1, 1'b0, 1'b0, 0);
    for (int k = 0; k < 5; k++) begin
      #1;
      check("fair_gnt", 32'(bus.req_ready), 32'(1 << (k % NREQ)));
      cycle();
    end

    // Illegal S=R=1 from requester 2, then a later error from requester 0
    idle();
    set_cmd(0, 1'b1, 1'b1, 1'b0, 1);
    cycle();
    idle();
    set_cmd(2, 1'b1, 1'b1, 1'b1, 1);
    cycle();
    check("ill_flags", 32'(flags), 32'h02);
    check("ill_src",   32'({err_ill, err_src}), 32'({1'b1, 2'd2}));
    idle();
    set_cmd(0, 1'b1, 1'b1, 1'b1, 3);
    cycle();
    check("ill_keep_src", 32'(err_src), 32'd2);

    // Range error, then clear coinciding with a new range error from requester 1
    idle();
    err_clr = 1'b1;
    cycle();
    idle();
    set_cmd(3, 1'b1, 1'b1, 1'b0, 7);
    cycle();
    check("rng_flags", 32'(flags), 32'h02);
    check("rng_set",   32'(err_rng), 32'd1);
    idle();
    err_clr = 1'b1;
    set_cmd(1, 1'b1, 1'b1, 1'b0, 6);
    cycle();
    check("clr_vs_new", 32'({err_ill, err_rng, err_src}), 32'({1'b0, 1'b1, 2'd1}));

    // Reset arriving during a granted set to flag 0
    idle();
    set_cmd(0, 1'b1, 1'b1, 1'b0, 0);
    reset = 1'b0;
    cycle();
    check("midrst_flags", 32'(flags), 32'h0);
    reset = 1'b1;
    for (int i = 0; i < NREQ; i++) set_cmd(i, 1'b1, 1'b0, 1'b0, 0);
    #1;
    check("midrst_ptr", 32'(bus.req_ready), 32'h1);
    cycle();

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      reset   = ($urandom_range(0, 39) != 0);
      err_clr = ($urandom_range(0, 7) == 0);
      for (int i = 0; i < NREQ; i++)
        set_cmd(i, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), int'($urandom_range(0, 7)));
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
